// File: rtl/priority_arbiter_rr.sv
// Request arbiter with selectable fixed or round-robin priority and a held,
// registered grant that is released by a valid/ready handshake.
//
// state | meaning
// IDLE  | no grant held, out_valid=0, out_idx=0, out_onehot=0
// HOLD  | grant held stable on out_idx/out_onehot until out_ready accepts it
module priority_arbiter_rr #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [W-1:0] TOP_IDX = W'(N - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [N-1:0]   onehot_q, onehot_d;
    logic [W-1:0]   ptr_q, ptr_d;

    logic           handshake;
    logic           evaluate;
    logic           any_req;
    logic [W-1:0]   ptr_after;
    logic [W-1:0]   ptr_eval;
    logic [W-1:0]   winner;

    function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] r);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (r[W'(i)]) w = W'(i);
        end
        return w;
    endfunction

    // Search downward from p (inclusive), wrapping from 0 back to N-1.
    function automatic logic [W-1:0] pick_rr(input logic [N-1:0] r, input logic [W-1:0] p);
        logic [W-1:0] w;
        logic         found;
        int           j;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(p) - k;
            if (j < 0) j = j + N;
            if (!found && r[W'(j)]) begin
                w     = W'(j);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            onehot_q <= '0;
            ptr_q    <= TOP_IDX;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            ptr_q    <= ptr_d;
        end
    end

    // The next winner after an accepted grant uses the already-advanced pointer.
    always_comb begin
        any_req   = |req;
        handshake = (state_q == HOLD) && out_ready;
        evaluate  = (state_q == IDLE) || handshake;
        ptr_after = (idx_q == '0) ? TOP_IDX : (idx_q - W'(1));
        ptr_eval  = handshake ? ptr_after : ptr_q;
        winner    = mode ? pick_rr(req, ptr_eval) : pick_fixed(req);
        state_d   = state_q;
        if (evaluate) begin
            state_d = any_req ? HOLD : IDLE;
        end
    end

    always_comb begin
        ptr_d    = handshake ? ptr_after : ptr_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        if (evaluate) begin
            if (any_req) begin
                idx_d    = winner;
                onehot_d = {{(N-1){1'b0}}, 1'b1} << winner;
            end else begin
                idx_d    = '0;
                onehot_d = '0;
            end
        end
    end

    assign out_valid  = (state_q == HOLD);
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed bench for priority_arbiter_rr (N=8) with a cycle-level reference
// model compared on every clock, plus literal checks of the expected grants.
module tb_priority_arbiter_rr;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_valid = 1'b0;
    int m_idx   = 0;
    int m_ptr   = N - 1;

    priority_arbiter_rr #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mode       (mode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int model_winner(input logic [N-1:0] r, input bit m, input int p);
        int j;
        if (!m) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) begin
                j = (p - k + N) % N;
                if (r[j]) return j;
            end
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = N - 1;
        end else if (!m_valid) begin
            if (req != '0) begin
                m_idx   = model_winner(req, mode, m_ptr);
                m_valid = 1'b1;
            end
        end else if (out_ready) begin
            m_ptr = (m_idx + N - 1) % N;
            if (req != '0) begin
                m_idx = model_winner(req, mode, m_ptr);
            end else begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
    end

    always @(posedge clk) begin
        int exp_oh;
        #1;
        exp_oh = m_valid ? (1 << m_idx) : 0;
        n_tests++;
        if (out_valid !== m_valid || int'(out_idx) != m_idx || int'(out_onehot) != exp_oh) begin
            n_fail++;
            $display("FAIL model t=%0t: got valid=%0d idx=%0d onehot=%02h, expected valid=%0d idx=%0d onehot=%02h",
                     $time, out_valid, out_idx, out_onehot, m_valid, m_idx, exp_oh);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_grant(input string name, input int exp_idx);
        chk({name, ".valid"}, int'(out_valid), 1);
        chk({name, ".idx"}, int'(out_idx), exp_idx);
        chk({name, ".onehot"}, int'(out_onehot), 1 << exp_idx);
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".valid"}, int'(out_valid), 0);
        chk({name, ".idx"}, int'(out_idx), 0);
        chk({name, ".onehot"}, int'(out_onehot), 0);
    endtask

    int sweep_exp [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int wrap_exp  [3] = '{0, 7, 0};

    initial begin
        rst       = 1'b1;
        req       = '0;
        mode      = 1'b0;
        out_ready = 1'b0;

        // Reset, then first round-robin grant matches fixed priority
        cyc();
        cyc();
        chk_idle("reset");
        rst  = 1'b0;
        mode = 1'b1;
        req  = 8'hFF;
        cyc();
        chk_grant("rr_first", 7);

        rst = 1'b1;
        cyc();
        chk_idle("reset2");

        // Fixed priority with held grant
        rst  = 1'b0;
        mode = 1'b0;
        req  = 8'h2C;
        cyc();
        chk_grant("fixed_first", 5);
        req = 8'h80;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_grant("fixed_hold", 5);
        end
        out_ready = 1'b1;
        cyc();
        chk_grant("fixed_accept", 7);

        // Drain to idle, then a fresh request
        req = 8'h00;
        cyc();
        chk_idle("drain");
        req       = 8'h04;
        out_ready = 1'b0;
        cyc();
        chk_grant("after_drain", 2);

        // Round-robin sweep, back-to-back
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        mode      = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk_grant("rr_sweep", sweep_exp[i]);
        end

        // Wrap: accept idx 1 then alternate between 0 and 7
        req = 8'h02;
        cyc();
        chk_grant("rr_to_1", 1);
        req = 8'h81;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_grant("rr_wrap", wrap_exp[i]);
        end

        // Hold idx 3 with the pointer at 3, then reset must restore pointer to 7
        req = 8'h10;
        cyc();
        chk_grant("rr_to_4", 4);
        req = 8'h88;
        cyc();
        chk_grant("rr_to_3", 3);
        out_ready = 1'b0;
        cyc();
        chk_grant("rr_hold_3", 3);
        rst = 1'b1;
        cyc();
        chk_idle("reset_mid_hold");
        rst = 1'b0;
        cyc();
        chk_grant("after_reset_ptr", 7);

        // Mode and req changes while held do not disturb the grant
        mode = 1'b0;
        req  = 8'h01;
        cyc();
        chk_grant("hold_mode_change", 7);
        out_ready = 1'b1;
        cyc();
        chk_grant("fixed_after_hold", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_arbiter_rr.md
PRIORITY_ARBITER_RR -- requirements
Module: priority_arbiter_rr

Interface
REQ-001 SHALL have parameter N, default 8: number of request lines, N >= 2.
REQ-002 SHALL have parameter W, default 3: index width, equal to ceil(log2(N)); widths other than that are unsupported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, N bits: request vector; bit i set means requester i is requesting.
REQ-006 SHALL have port mode, input, 1 bit: 0 selects fixed priority, 1 selects round-robin.
REQ-007 SHALL have port out_ready, input, 1 bit: the consumer accepts the current grant.
REQ-008 SHALL have port out_valid, output, 1 bit: a grant is held on out_idx and out_onehot.
REQ-009 SHALL have port out_idx, output, W bits: binary index of the granted requester.
REQ-010 SHALL have port out_onehot, output, N bits: one-hot form of out_idx; all zero when out_valid=0.

Function
REQ-011 SHALL register all outputs; no output depends combinationally on any input.
REQ-012 SHALL implement two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-013 IDLE with req=0: SHALL stay in IDLE with outputs unchanged (out_idx=0, out_onehot=0).
REQ-014 IDLE with req!=0: SHALL load the winner into out_idx and out_onehot and enter HOLD on that edge; latency from request to out_valid is exactly 1 cycle.
REQ-015 Fixed mode (mode=0): the winner SHALL be the highest set index of req; bit N-1 has top priority and bit 0 the lowest.
REQ-016 Round-robin mode (mode=1): SHALL hold an internal pointer p (W bits); the winner is the first set bit searching downward from p, wrapping from 0 to N-1.
REQ-017 Pointer update: on each handshake, p SHALL become (granted index - 1) mod N; granted index 0 sets p to N-1.
REQ-018 The pointer SHALL update only on a handshake (out_valid and out_ready both 1), in either mode; in mode 0 it tracks but does not affect selection.
REQ-019 HOLD with out_ready=0: out_idx, out_onehot and out_valid SHALL remain stable regardless of req or mode; a grant is never retracted, even if its req bit drops.
REQ-020 Handshake with req!=0: SHALL load the next winner on the same edge and stay in HOLD, giving back-to-back grants with no bubble cycle.
REQ-021 The next winner in REQ-020 SHALL be chosen using the pointer value after the REQ-017 update.
REQ-022 Handshake with req=0: SHALL enter IDLE and set out_valid=0, out_idx=0, out_onehot=0.
REQ-023 mode SHALL be sampled only at a winner-evaluation edge (REQ-014 or REQ-020); a change while in HOLD affects only the next evaluation.
REQ-024 out_onehot SHALL always equal 1 << out_idx while out_valid=1.
REQ-025 out_idx SHALL always be less than N.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, out_valid=0, out_idx=0, out_onehot=0 and p=N-1.
REQ-027 Reset SHALL override any simultaneous handshake or request.
REQ-028 After reset, the first round-robin grant SHALL equal the fixed-priority grant.
REQ-029 Reset asserted during HOLD SHALL discard the held grant with no handshake credit; p returns to N-1.

Verification (N=8)
REQ-030 Reset check: assert rst for 2 cycles -> out_valid=0, out_idx=0, out_onehot=0x00, and the next mode=1 grant with req=0xFF is idx 7.
REQ-031 Fixed-priority hold check:
- mode=0, req=0x2C, out_ready=0 -> one cycle later out_valid=1, out_idx=5, out_onehot=0x20.
- then req=0x80 for 3 cycles -> out_idx stays 5.
- then out_ready=1 -> next out_idx=7.
REQ-032 Round-robin sweep check: mode=1, req=0xFF, out_ready=1 constantly -> out_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles with no bubbles.
REQ-033 Round-robin wrap check: mode=1, grant idx 1 accepted, then req=0x81 -> next grant idx 0, then idx 7, then idx 0.
REQ-034 Drain check: handshake with req=0x00 -> next cycle out_valid=0 and out_onehot=0x00; req=0x04 then -> out_idx=2 one cycle later.
REQ-035 Reset mid-hold check:
- HOLD at idx 3 in mode=1, then rst=1 -> out_valid=0.
- then req=0x88 -> grant idx 7, which confirms p=N-1.
